// File: rtl/tlb_miss_ctrl_if.sv
// tlb_miss_ctrl_if
// Bundles every bus between the TLB miss controller and its neighbours:
//   request/response  : req_valid/req_ready/req_vaddr/req_write,
//                       resp_valid/resp_paddr/resp_hit/resp_fault
//   storage read      : rd_set_index -> rd_valid/rd_vpn/rd_ppn/rd_perms/rd_lru_count
//                       (flattened, way w occupies slice w)
//   storage refill    : wr_en, wr_set_index, wr_way, wr_valid, wr_vpn, wr_ppn,
//                       wr_perms, wr_lru_count
//   usage bump        : lru_update_en, lru_set_index, lru_way
//   page walker       : walk_req_valid/walk_req_ready/walk_req_vpn,
//                       walk_resp_valid/walk_resp_ppn/walk_resp_perms/walk_resp_fault
// Modport slave is the controller's view; master is the surrounding system.
interface tlb_miss_ctrl_if #(
    parameter int NUM_WAYS       = 4,
    parameter int SET_INDEX_BITS = 4,
    parameter int LRU_BITS       = 2
);
    logic                         req_valid;
    logic                         req_ready;
    logic [31:0]                  req_vaddr;
    logic                         req_write;
    logic                         resp_valid;
    logic [31:0]                  resp_paddr;
    logic                         resp_hit;
    logic                         resp_fault;
    logic [SET_INDEX_BITS-1:0]    rd_set_index;
    logic [NUM_WAYS-1:0]          rd_valid;
    logic [NUM_WAYS*20-1:0]       rd_vpn;
    logic [NUM_WAYS*20-1:0]       rd_ppn;
    logic [NUM_WAYS*2-1:0]        rd_perms;
    logic [NUM_WAYS*LRU_BITS-1:0] rd_lru_count;
    logic                         wr_en;
    logic [SET_INDEX_BITS-1:0]    wr_set_index;
    logic [1:0]                   wr_way;
    logic                         wr_valid;
    logic [19:0]                  wr_vpn;
    logic [19:0]                  wr_ppn;
    logic [1:0]                   wr_perms;
    logic [LRU_BITS-1:0]          wr_lru_count;
    logic                         lru_update_en;
    logic [SET_INDEX_BITS-1:0]    lru_set_index;
    logic [1:0]                   lru_way;
    logic                         walk_req_valid;
    logic                         walk_req_ready;
    logic [19:0]                  walk_req_vpn;
    logic                         walk_resp_valid;
    logic [19:0]                  walk_resp_ppn;
    logic [1:0]                   walk_resp_perms;
    logic                         walk_resp_fault;

    modport slave (
        input  req_valid, req_vaddr, req_write,
        output req_ready, resp_valid, resp_paddr, resp_hit, resp_fault,
        output rd_set_index,
        input  rd_valid, rd_vpn, rd_ppn, rd_perms, rd_lru_count,
        output wr_en, wr_set_index, wr_way, wr_valid, wr_vpn, wr_ppn, wr_perms, wr_lru_count,
        output lru_update_en, lru_set_index, lru_way,
        output walk_req_valid, walk_req_vpn,
        input  walk_req_ready,
        input  walk_resp_valid, walk_resp_ppn, walk_resp_perms, walk_resp_fault
    );

    modport master (
        output req_valid, req_vaddr, req_write,
        input  req_ready, resp_valid, resp_paddr, resp_hit, resp_fault,
        input  rd_set_index,
        output rd_valid, rd_vpn, rd_ppn, rd_perms, rd_lru_count,
        input  wr_en, wr_set_index, wr_way, wr_valid, wr_vpn, wr_ppn, wr_perms, wr_lru_count,
        input  lru_update_en, lru_set_index, lru_way,
        input  walk_req_valid, walk_req_vpn,
        output walk_req_ready,
        output walk_resp_valid, walk_resp_ppn, walk_resp_perms, walk_resp_fault
    );
endinterface

// File: rtl/tlb_miss_ctrl.sv
// tlb_miss_ctrl
// Translates one virtual address at a time against a set-associative TLB.
// A hit bumps the hit way's usage count; a miss picks a victim, asks the page
// walker for the translation, refills the victim way and answers. Every
// result is a one-cycle resp_valid pulse with registered, held data.
// Ports: clk, rst (synchronous, active-high), bus (tlb_miss_ctrl_if.slave).
module tlb_miss_ctrl #(
    parameter int NUM_WAYS       = 4,
    parameter int SET_INDEX_BITS = 4,
    parameter int LRU_BITS       = 2
) (
    input  logic            clk,
    input  logic            rst,
    tlb_miss_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, LOOKUP, WALK_REQ, WALK_WAIT, REFILL, RESP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   vaddr_q;
    logic          write_q;
    logic [1:0]    victim_q;
    logic [19:0]   walk_ppn_q;
    logic [1:0]    walk_perms_q;
    logic [31:0]   resp_paddr_q;
    logic          resp_hit_q;
    logic          resp_fault_q;

    logic [19:0]   vpn;
    logic          hit;
    logic [1:0]    hit_way;
    logic [19:0]   hit_ppn;
    logic [1:0]    hit_perms;
    logic          have_inv;
    logic [1:0]    inv_way;
    logic [1:0]    lru_way;
    logic [LRU_BITS-1:0] min_cnt;
    logic [1:0]    victim;

    function automatic logic perm_fault(input logic [1:0] perms, input logic is_write);
        return is_write ? ~perms[1] : ~perms[0];
    endfunction

    assign vpn = vaddr_q[31:12];

    // Descending scan so the lowest matching way is the last one written.
    always_comb begin
        hit       = 1'b0;
        hit_way   = 2'd0;
        hit_ppn   = 20'd0;
        hit_perms = 2'd0;
        have_inv  = 1'b0;
        inv_way   = 2'd0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (bus.rd_valid[w] && (bus.rd_vpn[w*20 +: 20] == vpn)) begin
                hit       = 1'b1;
                hit_way   = 2'(w);
                hit_ppn   = bus.rd_ppn[w*20 +: 20];
                hit_perms = bus.rd_perms[w*2 +: 2];
            end
            if (!bus.rd_valid[w]) begin
                have_inv = 1'b1;
                inv_way  = 2'(w);
            end
        end
    end

    // Strict less-than keeps the lowest index on a count tie.
    always_comb begin
        lru_way = 2'd0;
        min_cnt = bus.rd_lru_count[0 +: LRU_BITS];
        for (int w = 1; w < NUM_WAYS; w++) begin
            if (bus.rd_lru_count[w*LRU_BITS +: LRU_BITS] < min_cnt) begin
                lru_way = 2'(w);
                min_cnt = bus.rd_lru_count[w*LRU_BITS +: LRU_BITS];
            end
        end
        victim = have_inv ? inv_way : lru_way;
    end

    // Next state and control outputs. Storage writes are gated by rst so a
    // bump or refill coinciding with reset never reaches the storage.
    always_comb begin
        state_d            = state_q;
        bus.req_ready      = 1'b0;
        bus.lru_update_en  = 1'b0;
        bus.wr_en          = 1'b0;
        bus.walk_req_valid = 1'b0;
        bus.resp_valid     = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_d = LOOKUP;
            end
            LOOKUP: begin
                bus.lru_update_en = hit && !rst;
                state_d = hit ? RESP : WALK_REQ;
            end
            WALK_REQ: begin
                bus.walk_req_valid = 1'b1;
                if (bus.walk_req_ready) state_d = WALK_WAIT;
            end
            WALK_WAIT: begin
                if (bus.walk_resp_valid) state_d = bus.walk_resp_fault ? RESP : REFILL;
            end
            REFILL: begin
                bus.wr_en = !rst;
                state_d   = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rd_set_index  = vaddr_q[12 +: SET_INDEX_BITS];
    assign bus.lru_set_index = vaddr_q[12 +: SET_INDEX_BITS];
    assign bus.lru_way       = hit_way;
    assign bus.wr_set_index  = vaddr_q[12 +: SET_INDEX_BITS];
    assign bus.wr_way        = victim_q;
    assign bus.wr_valid      = bus.wr_en;
    assign bus.wr_vpn        = vpn;
    assign bus.wr_ppn        = walk_ppn_q;
    assign bus.wr_perms      = walk_perms_q;
    assign bus.wr_lru_count  = '0;
    assign bus.walk_req_vpn  = vpn;
    assign bus.resp_paddr    = resp_paddr_q;
    assign bus.resp_hit      = resp_hit_q;
    assign bus.resp_fault    = resp_fault_q;

    // Response registers only change on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            vaddr_q      <= '0;
            write_q      <= 1'b0;
            victim_q     <= 2'd0;
            walk_ppn_q   <= '0;
            walk_perms_q <= 2'd0;
            resp_paddr_q <= '0;
            resp_hit_q   <= 1'b0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.req_valid) begin
                vaddr_q <= bus.req_vaddr;
                write_q <= bus.req_write;
            end
            if (state_q == LOOKUP) begin
                victim_q <= victim;
                if (hit) begin
                    resp_paddr_q <= {hit_ppn, vaddr_q[11:0]};
                    resp_hit_q   <= 1'b1;
                    resp_fault_q <= perm_fault(hit_perms, write_q);
                end
            end
            if (state_q == WALK_WAIT && bus.walk_resp_valid) begin
                walk_ppn_q   <= bus.walk_resp_ppn;
                walk_perms_q <= bus.walk_resp_perms;
                if (bus.walk_resp_fault) begin
                    resp_paddr_q <= '0;
                    resp_hit_q   <= 1'b0;
                    resp_fault_q <= 1'b1;
                end
            end
            if (state_q == REFILL) begin
                resp_paddr_q <= {walk_ppn_q, vaddr_q[11:0]};
                resp_hit_q   <= 1'b0;
                resp_fault_q <= perm_fault(walk_perms_q, write_q);
            end
        end
    end
endmodule
